// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared mode encodings, state type and slot helpers for the Sobel scan controller
package sobel_pkg;

  localparam logic [1:0] MODE_VER = 2'd0;
  localparam logic [1:0] MODE_HOR = 2'd1;
  localparam logic [1:0] MODE_MAG = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic longint slot_count(input longint rows, input longint cols);
    return rows * cols + cols + 1;
  endfunction

  // The reserved encoding falls back to the vertical operator.
  function automatic logic [1:0] map_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? MODE_VER : mode;
  endfunction

endpackage

// File: rtl/sobel_tag_pipe.sv
// rtl/sobel_tag_pipe.sv - {valid, addr, border} shift register that tracks kernel results in flight
module sobel_tag_pipe #(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_border,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_border,
  output logic              o_pending
);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_border;
  logic [ADDR_W-1:0] r_addr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_border <= '0;
      for (int i = 0; i < DEPTH; i++) r_addr[i] <= '0;
    end else if (i_clr) begin
      r_valid  <= '0;
      r_border <= '0;
      for (int i = 0; i < DEPTH; i++) r_addr[i] <= '0;
    end else if (i_en) begin
      r_valid   <= {r_valid[DEPTH-2:0], i_valid};
      r_border  <= {r_border[DEPTH-2:0], i_border};
      r_addr[0] <= i_addr;
      for (int i = 1; i < DEPTH; i++) r_addr[i] <= r_addr[i-1];
    end
  end

  assign o_valid   = r_valid[DEPTH-1];
  assign o_addr    = r_addr[DEPTH-1];
  assign o_border  = r_border[DEPTH-1];
  // Entries still travelling toward the output stage.
  assign o_pending = |r_valid[DEPTH-2:0];

endmodule

// File: rtl/sobel_scan_ctrl.sv
// rtl/sobel_scan_ctrl.sv - raster-order frame sequencer for the streaming 3x3 Sobel kernel
module sobel_scan_ctrl
  import sobel_pkg::*;
#(
  parameter int ROWS   = 242,
  parameter int COLS   = 247,
  parameter int ADDR_W = 16,
  parameter int KLAT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        cfg_mode,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              kern_ce,
  output logic              kern_in_valid,
  output logic              kern_flush,
  output logic [1:0]        kern_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_border
);

  localparam longint SLOTS     = slot_count(ROWS, COLS);
  localparam int     NPIX      = ROWS * COLS;
  localparam int     LAST_SLOT = NPIX + COLS;
  localparam int     PRIME     = COLS + 1;
  localparam int     DEPTH     = 1 + KLAT;

  if ((longint'(1) << ADDR_W) < SLOTS) begin : g_addr_chk
    $error("sobel_scan_ctrl: ADDR_W too narrow for ROWS*COLS+COLS+1 slots");
  end
  if (KLAT < 1) begin : g_klat_chk
    $error("sobel_scan_ctrl: KLAT must be at least 1");
  end

  state_t            r_state;
  logic [ADDR_W-1:0] r_slot;
  logic [ADDR_W-1:0] r_crow;
  logic [ADDR_W-1:0] r_ccol;
  logic              r_kin_valid;
  logic              r_kin_flush;
  logic [1:0]        r_mode;

  logic              w_ce;
  logic              w_issue;
  logic              w_read;
  logic              w_centre;
  logic              w_border;
  logic              w_pending;
  logic              w_out_valid;
  logic [ADDR_W-1:0] w_c_addr;
  logic [ADDR_W-1:0] w_out_addr;
  logic              w_out_border;

  assign w_ce     = !(w_out_valid && !out_ready);
  assign w_issue  = (r_state == RUN);
  assign w_read   = w_issue && (r_slot < ADDR_W'(NPIX));
  // Slots below COLS+1 only prime the line buffers and carry no centre pixel.
  assign w_centre = w_issue && (r_slot >= ADDR_W'(PRIME));
  assign w_c_addr = r_slot - ADDR_W'(PRIME);
  assign w_border = (r_crow == '0) || (r_crow == ADDR_W'(ROWS - 1)) ||
                    (r_ccol == '0) || (r_ccol == ADDR_W'(COLS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_slot      <= '0;
      r_crow      <= '0;
      r_ccol      <= '0;
      r_kin_valid <= 1'b0;
      r_kin_flush <= 1'b0;
      r_mode      <= MODE_VER;
    end else if (abort) begin
      r_state     <= IDLE;
      r_slot      <= '0;
      r_crow      <= '0;
      r_ccol      <= '0;
      r_kin_valid <= 1'b0;
      r_kin_flush <= 1'b0;
    end else if (w_ce) begin
      r_kin_valid <= w_issue;
      r_kin_flush <= w_issue && !w_read;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode  <= map_mode(cfg_mode);
            r_slot  <= '0;
            r_crow  <= '0;
            r_ccol  <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_centre) begin
            if (r_ccol == ADDR_W'(COLS - 1)) begin
              r_ccol <= '0;
              r_crow <= r_crow + 1'b1;
            end else begin
              r_ccol <= r_ccol + 1'b1;
            end
          end
          if (r_slot == ADDR_W'(LAST_SLOT)) r_state <= DRAIN;
          else                              r_slot  <= r_slot + 1'b1;
        end
        DRAIN: begin
          // The output stage may still hold the last result; it retires on this enabled edge.
          if (!w_pending && !r_kin_valid) r_state <= DONE;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  sobel_tag_pipe #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_ce),
    .i_clr     (abort),
    .i_valid   (w_centre),
    .i_addr    (w_c_addr),
    .i_border  (w_border),
    .o_valid   (w_out_valid),
    .o_addr    (w_out_addr),
    .o_border  (w_out_border),
    .o_pending (w_pending)
  );

  assign busy          = (r_state == RUN) || (r_state == DRAIN);
  assign done          = (r_state == DONE);
  assign rd_en         = w_read;
  assign rd_addr       = w_read ? r_slot : '0;
  // Kernel is idle outside a frame, keeping the enable low from reset.
  assign kern_ce       = w_ce && busy;
  assign kern_in_valid = r_kin_valid;
  assign kern_flush    = r_kin_valid && r_kin_flush;
  assign kern_mode     = r_mode;
  assign out_valid     = w_out_valid;
  assign out_addr      = w_out_addr;
  assign out_border    = w_out_border;

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// tb/tb_sobel_scan_ctrl.sv - directed self-checking bench for sobel_scan_ctrl
module tb_sobel_scan_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 5;
  localparam int KLAT = 2;
  localparam int AW   = 8;
  localparam int NP   = ROWS * COLS;
  localparam int LAST = NP + COLS;
  localparam int LAT  = 1 + KLAT;
  localparam logic [31:0] INTERIOR = 32'h0000_39C0;

  logic          clk = 1'b0;
  logic          rst_n, rst2_n;
  logic          start, abort, out_ready;
  logic [1:0]    cfg_mode;
  logic          busy, done, rd_en, kern_ce, kern_in_valid, kern_flush, out_valid, out_border;
  logic [AW-1:0] rd_addr, out_addr;
  logic [1:0]    kern_mode;

  logic          d_start;
  logic          d_busy, d_done, d_rd_en, d_kern_ce, d_kin_valid, d_kflush, d_out_valid, d_out_border;
  logic [15:0]   d_rd_addr, d_out_addr;
  logic [1:0]    d_kern_mode;

  int n_vec  = 0;
  int n_fail = 0;
  int d_cnt = 0, d_done_cnt = 0, d_order_err = 0, d_last_addr = 0, d_last_border = 0;

  always #5 clk = ~clk;

  sobel_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(AW), .KLAT(KLAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_mode(cfg_mode),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .kern_ce(kern_ce),
    .kern_in_valid(kern_in_valid), .kern_flush(kern_flush), .kern_mode(kern_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_border(out_border)
  );

  sobel_scan_ctrl dut_full (
    .clk(clk), .rst_n(rst2_n), .start(d_start), .abort(1'b0), .cfg_mode(2'd2),
    .busy(d_busy), .done(d_done), .rd_en(d_rd_en), .rd_addr(d_rd_addr), .kern_ce(d_kern_ce),
    .kern_in_valid(d_kin_valid), .kern_flush(d_kflush), .kern_mode(d_kern_mode),
    .out_valid(d_out_valid), .out_ready(1'b1), .out_addr(d_out_addr), .out_border(d_out_border)
  );

  always @(negedge clk) begin
    if (d_out_valid) begin
      if (int'(d_out_addr) != d_cnt) d_order_err++;
      d_last_addr   = int'(d_out_addr);
      d_last_border = int'(d_out_border);
      d_cnt++;
    end
    if (d_done) d_done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [1:0] mode, input logic [1:0] exp_mode,
                           input int stall_e, input int stall_len, input int abort_e);
    int e, hold, oa;
    logic rdy, x_busy, x_rd, x_kiv, x_flush, x_ov, x_done, x_kce;
    logic [31:0] imask;
    imask = INTERIOR;
    e = 0;
    hold = 0;
    cfg_mode = mode; out_ready = 1'b1; abort = 1'b0; start = 1'b1;
    tick();
    for (int cyc = 0; cyc < 200; cyc++) begin
      rdy       = !(e == stall_e && hold < stall_len);
      out_ready = rdy;
      start     = (e == 5) || (e == abort_e);
      abort     = (e == abort_e);
      cfg_mode  = (e >= 10) ? ~mode : mode;
      #1;
      x_busy  = (e <= LAST + LAT);
      x_done  = (e == LAST + LAT + 1);
      x_rd    = (e < NP);
      x_kiv   = (e >= 1) && (e <= LAST + 1);
      x_flush = (e >= NP + 1) && (e <= LAST + 1);
      x_ov    = (e >= COLS + 1 + LAT) && (e <= LAST + LAT);
      x_kce   = x_busy && !(x_ov && !rdy);
      oa      = e - (COLS + 1 + LAT);
      chk("busy", busy, x_busy);
      chk("done", done, x_done);
      chk("rd_en", rd_en, x_rd);
      if (x_rd) chk("rd_addr", rd_addr, e);
      chk("kern_in_valid", kern_in_valid, x_kiv);
      chk("kern_flush", kern_flush, x_flush);
      chk("out_valid", out_valid, x_ov);
      if (x_ov) begin
        chk("out_addr", out_addr, oa);
        chk("out_border", out_border, !imask[oa]);
      end
      chk("kern_ce", kern_ce, x_kce);
      chk("kern_mode", kern_mode, exp_mode);
      if (!rdy) hold++;
      if (e == abort_e) begin
        tick();
        start = 1'b0; abort = 1'b0; cfg_mode = mode;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_kin_valid", kern_in_valid, 0);
        chk("abort_done", done, 0);
        repeat (6) begin
          tick();
          #1;
          chk("abort_no_done", done, 0);
          chk("abort_idle", busy, 0);
        end
        return;
      end
      if (x_done) begin
        tick();
        start = 1'b0; cfg_mode = mode;
        #1;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        return;
      end
      if (x_kce) e++;
      tick();
    end
    n_vec++;
    n_fail++;
    $error("FAIL frame_timeout: observed e=%0d expected done by e=%0d", e, LAST + LAT + 1);
  endtask

  initial begin
    rst_n = 1'b1; rst2_n = 1'b1;
    start = 1'b0; abort = 1'b0; out_ready = 1'b1; cfg_mode = 2'd0; d_start = 1'b0;
    #1;
    rst_n = 1'b0; rst2_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_kern_ce", kern_ce, 0);
    chk("rst_kin_valid", kern_in_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_kern_mode", kern_mode, 0);
    tick();
    rst_n = 1'b1; rst2_n = 1'b1;
    tick();
    d_start = 1'b1;
    tick();
    d_start = 1'b0;

    run_frame(2'd2, 2'd2, -1, 0, -1);
    run_frame(2'd3, 2'd0, 16, 4, -1);
    run_frame(2'd1, 2'd1, LAST + LAT, 2, -1);
    run_frame(2'd0, 2'd0, -1, 0, COLS + 1 + LAT + 10);
    run_frame(2'd2, 2'd2, -1, 0, -1);

    cfg_mode = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rd_en", rd_en, 0);
    chk("arst_rd_addr", rd_addr, 0);
    chk("arst_kin_valid", kern_in_valid, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_addr", out_addr, 0);
    chk("arst_kern_mode", kern_mode, 0);
    chk("arst_kern_ce", kern_ce, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_frame(2'd0, 2'd0, -1, 0, -1);

    for (int i = 0; i < 70000 && d_done_cnt == 0; i++) @(posedge clk);
    repeat (5) tick();
    chk("full_count", d_cnt, 59774);
    chk("full_last_addr", d_last_addr, 59773);
    chk("full_last_border", d_last_border, 1);
    chk("full_order", d_order_err, 0);
    chk("full_done_count", d_done_cnt, 1);
    chk("full_mode", d_kern_mode, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
